// File: rtl/im2col_sched.sv
// Row-window scheduler for im2col: walks the K-row window top address over a buffered frame.
// Optional stall counter output o_stall_cnt is built only when IM2COL_SCHED_PERF_EN is defined.
module im2col_sched #(
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int AW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pre_valid,
    output logic          o_pre_ready,
    output logic          o_win_valid,
    input  logic          i_win_ready,
    output logic [AW-1:0] o_addr,
    output logic          o_win_last,
    input  logic          i_abort,
    output logic          o_frame_done
`ifdef IM2COL_SCHED_PERF_EN
    ,
    output logic [15:0]   o_stall_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_H - K);

    generate
        if ((2 ** AW) <= (IMG_H - K)) begin : g_bad_aw
            $error("im2col_sched: AW too narrow for IMG_H-K");
        end
    endgenerate

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic          done_q;
    logic          at_last;

    assign at_last = (addr == LAST_ADDR);

    // Abort is checked before the handshake so it wins a same-cycle consume.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            IDLE: begin
                if (i_pre_valid) begin
                    state_nxt = RUN;
                    addr_nxt  = '0;
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_nxt = IDLE;
                    addr_nxt  = '0;
                end else if (i_win_ready) begin
                    if (at_last) begin
                        state_nxt = DONE;
                        addr_nxt  = '0;
                    end else begin
                        addr_nxt = addr + AW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            addr   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            done_q <= (state_nxt == DONE);
        end
    end

    // Outputs are forced low for the whole reset cycle, not just after the edge.
    assign o_pre_ready  = ~i_rst & (state == IDLE);
    assign o_win_valid  = ~i_rst & (state == RUN);
    assign o_win_last   = ~i_rst & (state == RUN) & at_last;
    assign o_addr       = i_rst ? '0 : addr;
    assign o_frame_done = ~i_rst & done_q;

`ifdef IM2COL_SCHED_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && i_pre_valid) begin
            stall_cnt <= '0;
        end else if (state == RUN && !i_win_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: doc/im2col_sched.md
IM2COL_SCHED -- requirements
Module: im2col_sched

Interface
REQ-001 SHALL have parameter IMG_H, default 28: input image height in rows.
REQ-002 SHALL have parameter K, default 3: kernel height (rows per window).
REQ-003 SHALL have parameter AW, default 5: row-address width; AW SHALL satisfy 2^AW > IMG_H-K.
REQ-004 SHALL have port i_clk  input  1: single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port i_pre_valid  input  1: image buffer holds a full frame.
REQ-007 SHALL have port o_pre_ready  output  1: scheduler accepts a new frame.
REQ-008 SHALL have port o_win_valid  output  1: window at o_addr is ready for im2col.
REQ-009 SHALL have port i_win_ready  input  1: im2col consumes the current window.
REQ-010 SHALL have port o_addr  output  AW: top row index of the current K-row window.
REQ-011 SHALL have port o_win_last  output  1: current window is the frame's last.
REQ-012 SHALL have port i_abort  input  1: cancels the frame in progress.
REQ-013 SHALL have port o_frame_done  output  1: one-cycle pulse when a frame completes.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE, with the state, o_addr and o_frame_done held in registers.
REQ-015 In IDLE: o_pre_ready=1 and o_win_valid=0; when i_pre_valid=1, next state RUN and o_addr<=0.
REQ-016 In RUN: o_win_valid=1 and o_pre_ready=0; the first window is valid in the cycle after the frame is accepted (latency 1).
REQ-017 In RUN, a handshake is o_win_valid & i_win_ready; on a handshake with o_addr<IMG_H-K, o_addr SHALL increment by 1.
REQ-018 On a handshake with o_addr==IMG_H-K: next state DONE and o_addr<=0; with default parameters a frame is exactly 26 windows (addr 0..25).
REQ-019 While o_win_valid=1 and i_win_ready=0, o_addr and o_win_last SHALL hold stable.
REQ-020 o_win_last SHALL be high iff the state is RUN and o_addr==IMG_H-K.
REQ-021 In DONE: o_frame_done=1 for exactly one cycle and o_pre_ready=0; next state IDLE.
REQ-022 Back-to-back frames: the minimum is (IMG_H-K+1)+2 cycles per frame (accept, windows, DONE).
REQ-023 i_abort=1 in RUN: next state IDLE and o_addr<=0, with no o_frame_done; i_abort has priority over a simultaneous handshake.
REQ-024 i_abort in IDLE or DONE SHALL be ignored.
REQ-025 i_pre_valid outside IDLE SHALL be ignored and SHALL NOT be accepted.

Reset
REQ-026 While i_rst=1: state IDLE, o_addr=0, o_frame_done=0, o_win_valid=0, o_win_last=0 and o_pre_ready=0.
REQ-027 o_pre_ready SHALL be 1 in the first cycle after i_rst is deasserted.
REQ-028 Reset asserted mid-RUN SHALL discard the frame without an o_frame_done pulse.
REQ-029 i_rst SHALL override i_abort and all handshakes.

Configuration
REQ-030 Macro IM2COL_SCHED_PERF_EN defined: the block SHALL add output o_stall_cnt [15:0].
REQ-031 With IM2COL_SCHED_PERF_EN defined, o_stall_cnt SHALL count RUN cycles with o_win_valid=1 and i_win_ready=0.
REQ-032 With IM2COL_SCHED_PERF_EN defined, o_stall_cnt SHALL clear on reset and on frame accept, saturate at 0xFFFF, and hold its value after DONE.
REQ-033 Macro IM2COL_SCHED_PERF_EN undefined: the o_stall_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Nominal frame: i_pre_valid=1 for one cycle and i_win_ready held 1 -> o_addr runs 0..25 in 26 consecutive cycles; o_win_last is high only at addr 25; o_frame_done pulses once, one cycle later.
REQ-035 Backpressure: i_win_ready=0 for 4 cycles at addr 7 -> o_addr holds at 7; with IM2COL_SCHED_PERF_EN defined, o_stall_cnt==4 at frame end.
REQ-036 Abort: i_abort=1 together with a handshake at addr 12 -> next cycle IDLE, o_addr=0, o_pre_ready=1, and no o_frame_done.
REQ-037 Reset mid-frame: i_rst=1 for one cycle at addr 20 -> all outputs 0 during reset; o_pre_ready=1 on the next cycle; no o_frame_done.
REQ-038 Back-to-back: i_pre_valid held 1 for two frames -> second frame accepted the cycle after o_frame_done; 56 cycles from the first accept to the second o_frame_done.
REQ-039 Parameters IMG_H=8, K=3 -> exactly 6 windows (addr 0..5); o_win_last high at addr 5.
